// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller
//
// Purpose: FSM state encoding, check/evaluate offsets relative to bit centre,
//          default frame width and the prescale value held after reset.
// Ports:   none (package).

package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Sampler votes edges P/2-1..P/2+1, so the bit is stable at P/2+CHECK_OFS;
  // checker flags come back registered one edge later, at P/2+EVAL_OFS.
  localparam int CHECK_OFS  = 2;
  localparam int EVAL_OFS   = 3;
  localparam int DATA_W_DEF = 8;
  localparam int P_RESET    = 8;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and data bit counter
//
// Purpose: counts oversample edges within a bit (0..P-1, wrapping at P-1) and
//          data bit positions, advancing the bit index on each edge wrap.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en         edge counter runs while high
//   clr        forces edge_cnt to 0 (has priority over en)
//   bit_en     allow bit_cnt to advance on the last edge of a bit
//   bit_clr    forces bit_cnt to 0 (has priority over bit_en)
//   p_val      latched oversampling ratio P
//   edge_cnt   current edge index
//   bit_cnt    current data bit index
//   edge_last  high while edge_cnt == P-1

module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  bit_en,
  input  logic                  bit_clr,
  input  logic [PRESCALE_W-1:0] p_val,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  edge_last
);

  assign edge_last = (edge_cnt == (p_val - PRESCALE_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (en) begin
      edge_cnt <= edge_last ? '0 : edge_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_en && edge_last) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing controller
//
// Purpose: detects the start-bit fall, runs the per-bit oversample timebase,
//          strobes the start/data/parity/stop datapath at bit centre and turns
//          the checker flags into one data_valid or frame_err pulse per frame.
// Ports:
//   clk, rst        oversampling clock, asynchronous active-low reset
//   rx_in           synchronized serial line, idle high
//   prescale        oversampling ratio P (8, 16 or 32), latched at frame start
//   par_en          frame carries a parity bit, latched at frame start
//   start_err       start checker flag, valid the cycle after start_check_en
//   par_err         parity checker flag, valid the cycle after par_check_en
//   stop_err        stop checker flag, valid the cycle after stop_check_en
//   dat_samp_en     sampler enable, high outside IDLE
//   edge_cnt        oversample edge index within the current bit
//   bit_cnt         data bit index, 0 outside DATA
//   start_check_en  strobe to start checker at edge P/2+2
//   deser_en        strobe to deserializer at edge P/2+2 of each data bit
//   par_check_en    strobe to parity checker at edge P/2+2
//   stop_check_en   strobe to stop checker at edge P/2+2
//   data_valid      one-cycle pulse: clean frame
//   frame_err       one-cycle pulse: parity or stop error

module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  start_err,
  input  logic                  par_err,
  input  logic                  stop_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  start_check_en,
  output logic                  deser_en,
  output logic                  par_check_en,
  output logic                  stop_check_en,
  output logic                  data_valid,
  output logic                  frame_err
);

  rx_state_e             state;
  logic [PRESCALE_W-1:0] p_lat;
  logic [PRESCALE_W-1:0] half_p;
  logic                  par_en_lat;
  logic                  par_sticky;
  logic                  edge_last;
  logic                  at_chk_pre;
  logic                  at_eval;
  logic                  bit_last;
  logic                  leave;
  logic                  cnt_clr;
  logic                  bit_clr;

  assign half_p = p_lat >> 1;

  // Strobes are registered, so they are set one edge early to be high
  // exactly while edge_cnt == P/2+CHECK_OFS.
  assign at_chk_pre = (edge_cnt == half_p + PRESCALE_W'(CHECK_OFS - 1));
  assign at_eval    = (edge_cnt == half_p + PRESCALE_W'(EVAL_OFS));
  assign bit_last   = (bit_cnt == 4'(DATA_W - 1));

  // Early exits (start glitch, mid-stop-bit exit) reset the timebase together
  // with the state so a following start sees edge 0.
  assign leave   = ((state == START) && at_eval && start_err) ||
                   ((state == STOP) && at_eval);
  assign cnt_clr = (state == IDLE) || leave;
  assign bit_clr = (state != DATA) || (edge_last && bit_last);

  assign dat_samp_en = (state != IDLE);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .clr       (cnt_clr),
    .bit_en    (state == DATA),
    .bit_clr   (bit_clr),
    .p_val     (p_lat),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .edge_last (edge_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      p_lat          <= PRESCALE_W'(P_RESET);
      par_en_lat     <= 1'b0;
      par_sticky     <= 1'b0;
      start_check_en <= 1'b0;
      deser_en       <= 1'b0;
      par_check_en   <= 1'b0;
      stop_check_en  <= 1'b0;
      data_valid     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      start_check_en <= 1'b0;
      deser_en       <= 1'b0;
      par_check_en   <= 1'b0;
      stop_check_en  <= 1'b0;
      data_valid     <= 1'b0;
      frame_err      <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_in) begin
            state      <= START;
            p_lat      <= prescale;
            par_en_lat <= par_en;
            par_sticky <= 1'b0;
          end
        end

        START: begin
          if (at_chk_pre) start_check_en <= 1'b1;
          // Error check wins over the P-1 boundary when P/2+3 == P-1 (P=8).
          if (at_eval && start_err) begin
            state <= IDLE;
          end else if (edge_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (at_chk_pre) deser_en <= 1'b1;
          if (edge_last && bit_last) begin
            state <= par_en_lat ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (at_chk_pre) par_check_en <= 1'b1;
          if (at_eval) par_sticky <= par_err;
          if (edge_last) state <= STOP;
        end

        STOP: begin
          if (at_chk_pre) stop_check_en <= 1'b1;
          if (at_eval) begin
            if (!stop_err && !par_sticky) begin
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            par_sticky <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl

module tb_uart_rx_ctrl;

  localparam int K_START = 0;
  localparam int K_DESER = 1;
  localparam int K_PAR   = 2;
  localparam int K_STOP  = 3;
  localparam int K_DV    = 4;
  localparam int K_FE    = 5;

  typedef struct {
    int kind;
    int edge_i;
    int bit_i;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       start_err = 1'b0;
  logic       par_err = 1'b0;
  logic       stop_err = 1'b0;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       start_check_en;
  logic       deser_en;
  logic       par_check_en;
  logic       stop_check_en;
  logic       data_valid;
  logic       frame_err;
  logic [16:0] outs;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  last_stop_cyc = -100;
  bit  plan_start = 0;
  bit  plan_par = 0;
  bit  plan_stop = 0;

  uart_rx_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .prescale       (prescale),
    .par_en         (par_en),
    .start_err      (start_err),
    .par_err        (par_err),
    .stop_err       (stop_err),
    .dat_samp_en    (dat_samp_en),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .start_check_en (start_check_en),
    .deser_en       (deser_en),
    .par_check_en   (par_check_en),
    .stop_check_en  (stop_check_en),
    .data_valid     (data_valid),
    .frame_err      (frame_err)
  );

  assign outs = {dat_samp_en, edge_cnt, bit_cnt, start_check_en, deser_en,
                 par_check_en, stop_check_en, data_valid, frame_err};

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic push(input int k, input int e, input int b);
    ev_t ev;
    ev.kind = k;
    ev.edge_i = e;
    ev.bit_i = b;
    exp_q.push_back(ev);
  endtask

  task automatic drive_bit(input logic v, input int p);
    rx_in = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One full frame at ratio p; p_mid is written to prescale after the start
  // bit and must not affect timing.
  task automatic send_frame(input int p, input logic [7:0] d, input bit pe,
                            input bit bad_par, input bit bad_stop, input int p_mid);
    int h;
    h = p / 2;
    plan_start = 0;
    plan_par = bad_par;
    plan_stop = bad_stop;
    prescale = 6'(p);
    par_en = pe;
    push(K_START, h + 2, 0);
    for (int i = 0; i < 8; i++) push(K_DESER, h + 2, i);
    if (pe) push(K_PAR, h + 2, 0);
    push(K_STOP, h + 2, 0);
    push((bad_stop || (pe && bad_par)) ? K_FE : K_DV, 0, 0);
    drive_bit(1'b0, p);
    prescale = 6'(p_mid);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(^d, p);
    drive_bit(1'b1, p);
  endtask

  // Checker model: flag raised for the cycle after its strobe, as planned.
  initial begin
    bit sc_p, pc_p, st_p;
    sc_p = 0;
    pc_p = 0;
    st_p = 0;
    forever begin
      @(negedge clk);
      start_err = sc_p;
      par_err = pc_p;
      stop_err = st_p;
      sc_p = start_check_en && plan_start;
      pc_p = par_check_en && plan_par;
      st_p = stop_check_en && plan_stop;
    end
  end

  // Monitor: every strobe or pulse must match the head of the queue.
  initial begin
    logic [5:0] evs;
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        evs = {frame_err, data_valid, stop_check_en, par_check_en, deser_en, start_check_en};
        if (data_valid || frame_err)
          check("pulse_exclusive", int'(data_valid & frame_err), 0);
        for (int k = 0; k < 6; k++) begin
          if (evs[k]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_event", k, -1);
            end else begin
              e = exp_q.pop_front();
              check("event_kind", k, e.kind);
              if (k <= K_STOP) begin
                check("event_edge", int'(edge_cnt), e.edge_i);
                check("event_bit", int'(bit_cnt), e.bit_i);
              end else begin
                check("pulse_latency", cyc - last_stop_cyc, 2);
              end
              if (k == K_STOP) last_stop_cyc = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_outputs", int'(outs), 0);
    repeat (2) @(negedge clk);

    // P=8, no parity, 0xA5, clean
    send_frame(8, 8'hA5, 0, 0, 0, 8);
    idle(6);
    // P=16, parity error -> frame_err
    send_frame(16, 8'h3C, 1, 1, 0, 16);
    idle(6);
    // P=16, parity clean -> data_valid
    send_frame(16, 8'h3C, 1, 0, 0, 16);
    idle(6);

    // Start glitch: only the start strobe, then back to IDLE
    plan_start = 1;
    plan_par = 0;
    plan_stop = 0;
    prescale = 6'd8;
    par_en = 1'b0;
    push(K_START, 6, 0);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", int'(dat_samp_en), 0);
    plan_start = 0;

    // P=32, back-to-back 0x00 then 0xFF
    send_frame(32, 8'h00, 0, 0, 0, 32);
    send_frame(32, 8'hFF, 0, 0, 0, 32);
    idle(6);

    // Stop error, then a clean frame (prescale changed mid-frame, ignored)
    send_frame(8, 8'h5A, 0, 0, 1, 8);
    idle(6);
    send_frame(8, 8'h81, 0, 0, 0, 16);
    idle(6);

    // Reset during data bit 3: no pulse for the aborted frame
    plan_start = 0;
    plan_par = 0;
    plan_stop = 0;
    prescale = 6'd8;
    par_en = 1'b0;
    push(K_START, 6, 0);
    for (int i = 0; i < 3; i++) push(K_DESER, 6, i);
    rx_in = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      rx_in = 1'b1;
      if (bit_cnt == 4'd3 && edge_cnt == 6'd2) found = 1;
    end
    check("reached_bit3", int'(found), 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", int'(outs), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_release_outputs", int'(outs), 0);
    repeat (30) @(negedge clk);
    check("idle_after_reset", int'(dat_samp_en), 0);

    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
